// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute-stage sequencer in front of a combinational RV32I ALU.
//
// The stage has two pipeline registers:
//   - Stage A holds a decoded instruction. It drives alu_op, alu_x and alu_y.
//   - Stage B captures the ALU result and flag into registered outputs.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready decode-side handshake
//   in_opcode, in_funct3, in_funct7, in_pc, in_rs1, in_rs2, in_imm, in_rd
//                     decoded instruction fields
//   alu_op, alu_x, alu_y  drive to the external ALU (zero while A is empty)
//   alu_result, alu_flag  combinational ALU response
//   out_valid/out_ready   writeback-side handshake
//   out_result, out_rd, out_we, out_br_taken, out_br_target, out_illegal
//                     registered execute results
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rd,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  input  logic [31:0] alu_result,
  input  logic        alu_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_br_taken,
  output logic [31:0] out_br_target,
  output logic        out_illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_EQ  = 4'b1000;
  localparam logic [3:0] OP_NE  = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_GE  = 4'b1011;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Stage A: decoded instruction
  logic        a_valid_q;
  logic [3:0]  a_op_q;
  logic [31:0] a_x_q, a_y_q, a_tgt_q;
  logic [4:0]  a_rd_q;
  logic        a_we_q, a_br_q, a_jmp_q, a_ill_q;

  // Stage B: registered results
  logic        b_valid_q;
  logic [31:0] b_result_q, b_tgt_q;
  logic [4:0]  b_rd_q;
  logic        b_we_q, b_taken_q, b_ill_q;

  // Decoder outputs
  logic [3:0]  dec_op_d;
  logic [31:0] dec_x_d, dec_y_d, dec_tgt_d;
  logic        dec_legal, dec_wb, dec_br, dec_jmp;
  logic [31:0] br_sum, jalr_sum, y_src;
  logic        is_reg, f7_zero;

  logic        b_free, in_fire;
  logic [31:0] b_result_d;
  logic        b_taken_d;

  assign b_free   = !b_valid_q || out_ready;
  assign in_ready = !a_valid_q || b_free;
  assign in_fire  = in_valid && in_ready;

  // Instruction decode into ALU opcode, operands and control fields
  always_comb begin
    dec_op_d  = OP_AND;
    dec_x_d   = 32'd0;
    dec_y_d   = 32'd0;
    dec_tgt_d = 32'd0;
    dec_legal = 1'b0;
    dec_wb    = 1'b0;
    dec_br    = 1'b0;
    dec_jmp   = 1'b0;
    // Dedicated target adders, independent of the ALU
    br_sum    = in_pc + in_imm;
    jalr_sum  = in_rs1 + in_imm;
    is_reg    = (in_opcode == OPC_OP);
    f7_zero   = (in_funct7 == 7'b0000000);
    y_src     = is_reg ? in_rs2 : in_imm;
    case (in_opcode)
      OPC_OP, OPC_OPIMM: begin
        dec_x_d = in_rs1;
        dec_y_d = y_src;
        dec_wb  = 1'b1;
        case (in_funct3)
          3'b000: begin
            // OP-IMM f3=000 is always ADDI; register form selects by funct7
            if (!is_reg || f7_zero) begin
              dec_op_d  = OP_ADD;
              dec_legal = 1'b1;
            end else if (in_funct7 == 7'b0100000) begin
              dec_op_d  = OP_SUB;
              dec_legal = 1'b1;
            end else if (in_funct7 == 7'b0000001) begin
              dec_op_d  = OP_MUL;
              dec_legal = 1'b1;
            end else begin
              dec_legal = 1'b0;
            end
          end
          3'b111: begin dec_op_d = OP_AND; dec_legal = !is_reg || f7_zero; end
          3'b110: begin dec_op_d = OP_OR;  dec_legal = !is_reg || f7_zero; end
          3'b100: begin dec_op_d = OP_XOR; dec_legal = !is_reg || f7_zero; end
          3'b010: begin dec_op_d = OP_LT;  dec_legal = !is_reg || f7_zero; end
          3'b001: begin
            dec_op_d  = OP_SLL;
            dec_y_d   = {27'd0, y_src[4:0]};
            dec_legal = f7_zero;
          end
          3'b101: begin
            // funct7=0100000 (SRA/SRAI) is not supported and falls out illegal
            dec_op_d  = OP_SRL;
            dec_y_d   = {27'd0, y_src[4:0]};
            dec_legal = f7_zero;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        dec_x_d   = in_rs1;
        dec_y_d   = in_rs2;
        dec_br    = 1'b1;
        dec_tgt_d = br_sum;
        case (in_funct3)
          3'b000:  begin dec_op_d = OP_EQ; dec_legal = 1'b1; end
          3'b001:  begin dec_op_d = OP_NE; dec_legal = 1'b1; end
          3'b100:  begin dec_op_d = OP_LT; dec_legal = 1'b1; end
          3'b101:  begin dec_op_d = OP_GE; dec_legal = 1'b1; end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec_op_d = OP_ADD; dec_y_d = in_imm; dec_wb = 1'b1; dec_legal = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op_d = OP_ADD; dec_x_d = in_pc; dec_y_d = in_imm;
        dec_wb = 1'b1; dec_legal = 1'b1;
      end
      OPC_LOAD, OPC_STORE: begin
        dec_op_d = OP_ADD; dec_x_d = in_rs1; dec_y_d = in_imm; dec_legal = 1'b1;
      end
      OPC_JAL: begin
        dec_op_d = OP_ADD; dec_x_d = in_pc; dec_y_d = 32'd4;
        dec_wb = 1'b1; dec_jmp = 1'b1; dec_tgt_d = br_sum; dec_legal = 1'b1;
      end
      OPC_JALR: begin
        dec_op_d = OP_ADD; dec_x_d = in_pc; dec_y_d = 32'd4;
        dec_wb = 1'b1; dec_jmp = 1'b1; dec_tgt_d = jalr_sum & ~32'd1;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Stage A register: load on accept, empty when its content moves to B
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_op_q    <= OP_AND;
      a_x_q     <= 32'd0;
      a_y_q     <= 32'd0;
      a_tgt_q   <= 32'd0;
      a_rd_q    <= 5'd0;
      a_we_q    <= 1'b0;
      a_br_q    <= 1'b0;
      a_jmp_q   <= 1'b0;
      a_ill_q   <= 1'b0;
    end else if (in_fire) begin
      // Illegal instructions are squashed to a zeroed, side-effect-free slot
      a_valid_q <= 1'b1;
      a_op_q    <= dec_legal ? dec_op_d : OP_AND;
      a_x_q     <= dec_legal ? dec_x_d : 32'd0;
      a_y_q     <= dec_legal ? dec_y_d : 32'd0;
      a_tgt_q   <= dec_legal ? dec_tgt_d : 32'd0;
      a_rd_q    <= in_rd;
      a_we_q    <= dec_legal && dec_wb && (in_rd != 5'd0);
      a_br_q    <= dec_legal && dec_br;
      a_jmp_q   <= dec_legal && dec_jmp;
      a_ill_q   <= !dec_legal;
    end else if (b_free) begin
      a_valid_q <= 1'b0;
    end
  end

  assign alu_op = a_valid_q ? a_op_q : OP_AND;
  assign alu_x  = a_valid_q ? a_x_q : 32'd0;
  assign alu_y  = a_valid_q ? a_y_q : 32'd0;

  assign b_result_d = a_ill_q ? 32'd0 : alu_result;
  assign b_taken_d  = a_br_q ? alu_flag : a_jmp_q;

  // Stage B register: capture ALU response whenever B can accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid_q  <= 1'b0;
      b_result_q <= 32'd0;
      b_tgt_q    <= 32'd0;
      b_rd_q     <= 5'd0;
      b_we_q     <= 1'b0;
      b_taken_q  <= 1'b0;
      b_ill_q    <= 1'b0;
    end else if (b_free) begin
      b_valid_q <= a_valid_q;
      if (a_valid_q) begin
        b_result_q <= b_result_d;
        b_tgt_q    <= a_tgt_q;
        b_rd_q     <= a_rd_q;
        b_we_q     <= a_we_q;
        b_taken_q  <= b_taken_d;
        b_ill_q    <= a_ill_q;
      end
    end
  end

  assign out_valid     = b_valid_q;
  assign out_result    = b_result_q;
  assign out_rd        = b_rd_q;
  assign out_we        = b_we_q;
  assign out_br_taken  = b_taken_q;
  assign out_br_target = b_tgt_q;
  assign out_illegal   = b_ill_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: behavioural ALU, reference model and
// in-order scoreboard checked every cycle the output is valid.
module tb_alu_exec_stage;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        we;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode, in_funct7;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic [4:0]  in_rd;
  logic [3:0]  alu_op;
  logic [31:0] alu_x, alu_y, alu_result;
  logic        alu_flag;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_br_target;
  logic [4:0]  out_rd;
  logic        out_we, out_br_taken, out_illegal;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_exec_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
    .alu_op(alu_op), .alu_x(alu_x), .alu_y(alu_y),
    .alu_result(alu_result), .alu_flag(alu_flag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we),
    .out_br_taken(out_br_taken), .out_br_target(out_br_target),
    .out_illegal(out_illegal)
  );

  // Behavioural combinational ALU
  always_comb begin
    alu_flag = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_x & alu_y;
      4'b0001: alu_result = alu_x | alu_y;
      4'b0010: alu_result = alu_x ^ alu_y;
      4'b0011: alu_result = alu_x + alu_y;
      4'b0100: alu_result = alu_x - alu_y;
      4'b0101: alu_result = alu_x * alu_y;
      4'b0110: alu_result = alu_x >> alu_y[4:0];
      4'b0111: alu_result = alu_x << alu_y[4:0];
      4'b1000: alu_flag = (alu_x == alu_y);
      4'b1001: alu_flag = (alu_x != alu_y);
      4'b1010: alu_flag = ($signed(alu_x) < $signed(alu_y));
      4'b1011: alu_flag = ($signed(alu_x) >= $signed(alu_y));
      default: alu_result = 32'd0;
    endcase
    if (alu_op[3]) alu_result = {31'd0, alu_flag};
  end

  // Reference model: expected registered outputs for one instruction
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [4:0] rd);
    exp_t e;
    logic legal, wb, reg_form;
    logic [31:0] b;
    e = '0;
    e.rd = rd;
    legal = 1'b1;
    wb = 1'b0;
    reg_form = (op == OPC_OP);
    b = reg_form ? rs2 : imm;
    case (op)
      OPC_OP, OPC_OPIMM: begin
        wb = 1'b1;
        case (f3)
          3'b000: if (!reg_form || f7 == 7'd0) e.result = rs1 + b;
                  else if (f7 == 7'b0100000) e.result = rs1 - b;
                  else if (f7 == 7'b0000001) e.result = rs1 * b;
                  else legal = 1'b0;
          3'b111: begin e.result = rs1 & b; legal = !reg_form || f7 == 7'd0; end
          3'b110: begin e.result = rs1 | b; legal = !reg_form || f7 == 7'd0; end
          3'b100: begin e.result = rs1 ^ b; legal = !reg_form || f7 == 7'd0; end
          3'b010: begin e.result = {31'd0, $signed(rs1) < $signed(b)}; legal = !reg_form || f7 == 7'd0; end
          3'b001: begin e.result = rs1 << b[4:0]; legal = (f7 == 7'd0); end
          3'b101: begin e.result = rs1 >> b[4:0]; legal = (f7 == 7'd0); end
          default: legal = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        e.target = pc + imm;
        case (f3)
          3'b000: e.taken = (rs1 == rs2);
          3'b001: e.taken = (rs1 != rs2);
          3'b100: e.taken = ($signed(rs1) < $signed(rs2));
          3'b101: e.taken = ($signed(rs1) >= $signed(rs2));
          default: legal = 1'b0;
        endcase
        e.result = {31'd0, e.taken};
      end
      OPC_LUI:   begin e.result = imm; wb = 1'b1; end
      OPC_AUIPC: begin e.result = pc + imm; wb = 1'b1; end
      OPC_LOAD, OPC_STORE: e.result = rs1 + imm;
      OPC_JAL:  begin e.result = pc + 32'd4; wb = 1'b1; e.taken = 1'b1; e.target = pc + imm; end
      OPC_JALR: begin e.result = pc + 32'd4; wb = 1'b1; e.taken = 1'b1; e.target = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      e = '0;
      e.rd = rd;
      e.illegal = 1'b1;
    end else begin
      e.we = wb && (rd != 5'd0);
    end
    return e;
  endfunction

  // Scoreboard: compare head every valid cycle (also proves hold stability), push on accept
  always @(negedge clk) begin
    exp_t obs;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected: out_valid with no pending instruction, result=%h", out_result);
        end
        if (sb.size() != 0) begin
          obs = {out_result, out_rd, out_we, out_br_taken, out_br_target, out_illegal};
          checks++;
          assert (obs === sb[0]) else begin
            errors++;
            $error("FAIL sb_compare: got %h expected %h", obs, sb[0]);
          end
          if (out_ready) void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_opcode, in_funct3, in_funct7, in_pc, in_rs1, in_rs2, in_imm, in_rd));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one instruction and hold it until accepted (bounded)
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [31:0] imm, input logic [4:0] rd);
    int n;
    in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL send_timeout: in_ready low for %0d cycles, required accept", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_result"}, out_result, 32'd0);
    chk({tag, "_out_misc"}, {25'd0, out_rd, out_we, out_br_taken}, 32'd0);
    chk({tag, "_out_target"}, out_br_target, 32'd0);
    chk({tag, "_out_illegal"}, {31'd0, out_illegal}, 32'd0);
    chk({tag, "_alu_op"}, {28'd0, alu_op}, 32'd0);
    chk({tag, "_alu_x"}, alu_x, 32'd0);
    chk({tag, "_alu_y"}, alu_y, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_opcode = 7'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
    in_pc = 32'd0; in_rs1 = 32'd0; in_rs2 = 32'd0; in_imm = 32'd0; in_rd = 5'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD overflow wrap with explicit 2-cycle latency check
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd5);
    chk("add_latency_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("add_out_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'h8000_0000);
    chk("add_we", {31'd0, out_we}, 32'd1);
    chk("add_taken_illegal", {30'd0, out_br_taken, out_illegal}, 32'd0);

    // SLLI with shamt masked to 5 bits
    send(OPC_OPIMM, 3'b001, 7'b0000000, 32'h0, 32'h1, 32'h0, 32'h23, 5'd6);
    chk("slli_alu_op", {28'd0, alu_op}, 32'h7);
    chk("slli_alu_y", alu_y, 32'h3);
    // SRAI, SLTU, BLTU: unsupported encodings
    send(OPC_OPIMM, 3'b101, 7'b0100000, 32'h0, 32'h8000_0000, 32'h0, 32'h1, 5'd7);
    send(OPC_OP, 3'b011, 7'b0000000, 32'h0, 32'h1, 32'h2, 32'h0, 5'd8);
    send(OPC_BRANCH, 3'b110, 7'b0000000, 32'h40, 32'h1, 32'h2, 32'h8, 5'd0);
    // Branches
    send(OPC_BRANCH, 3'b100, 7'b0000000, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF0, 5'd0);
    send(OPC_BRANCH, 3'b101, 7'b0000000, 32'h100, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFF0, 5'd0);
    send(OPC_BRANCH, 3'b000, 7'b0000000, 32'h300, 32'h55, 32'h55, 32'h20, 5'd0);
    send(OPC_BRANCH, 3'b001, 7'b0000000, 32'h300, 32'h55, 32'h55, 32'h20, 5'd0);
    // Jumps
    send(OPC_JALR, 3'b000, 7'b0000000, 32'h200, 32'h1001, 32'h0, 32'h4, 5'd1);
    send(OPC_JAL, 3'b000, 7'b0000000, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h10, 5'd0);
    // Remaining ALU operations and address/upper-immediate forms
    send(OPC_OP, 3'b000, 7'b0100000, 32'h0, 32'h5, 32'h7, 32'h0, 5'd9);
    send(OPC_OP, 3'b000, 7'b0000001, 32'h0, 32'h1234, 32'h10001, 32'h0, 5'd10);
    send(OPC_OP, 3'b101, 7'b0000000, 32'h0, 32'hF000_0000, 32'hFFFF_FFE4, 32'h0, 5'd11);
    send(OPC_OP, 3'b010, 7'b0000000, 32'h0, 32'h8000_0000, 32'h1, 32'h0, 5'd12);
    send(OPC_OP, 3'b111, 7'b0000001, 32'h0, 32'hFF, 32'hF0, 32'h0, 5'd13);
    send(OPC_OPIMM, 3'b110, 7'b1111111, 32'h0, 32'h0F, 32'h0, 32'hFFFF_FF00, 5'd14);
    send(OPC_LUI, 3'b000, 7'b0000000, 32'h0, 32'hDEAD, 32'h0, 32'hABCD_E000, 5'd15);
    send(OPC_AUIPC, 3'b000, 7'b0000000, 32'hFFFF_F000, 32'h0, 32'h0, 32'h0000_2000, 5'd16);
    send(OPC_LOAD, 3'b010, 7'b0000000, 32'h0, 32'h1000, 32'h0, 32'hFFFF_FFFC, 5'd17);
    send(OPC_STORE, 3'b010, 7'b0000000, 32'h0, 32'h2000, 32'h9, 32'h8, 5'd18);
    send(7'b1110011, 3'b000, 7'b0000000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd19);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: 4 ADDs, out_ready low for 3 cycles
    out_ready = 1'b0;
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h10, 32'h1, 32'h0, 5'd20);
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h20, 32'h2, 32'h0, 5'd21);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("stall_alu_x_hold", alu_x, 32'h20);
    out_ready = 1'b1;
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h30, 32'h3, 32'h0, 5'd22);
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h40, 32'h4, 32'h0, 5'd23);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_stream", sb.size(), 32'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h1, 32'h1, 32'h0, 5'd24);
    send(OPC_OP, 3'b000, 7'b0000000, 32'h0, 32'h2, 32'h2, 32'h0, 5'd25);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check_zero_outputs("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_reset_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_no_output", {31'd0, out_valid}, 32'd0);

    // Stream resumes after reset
    send(OPC_OPIMM, 3'b100, 7'b0000000, 32'h0, 32'hAAAA_5555, 32'h0, 32'hFFFF_FFFF, 5'd26);
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("final_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
